// File: rtl/std_spram_arb2.sv
// Two-requester arbiter in front of one single-port SRAM. Read data is captured
// into a per-port response register, so one port's response backpressure never blocks the other.
module std_spram_arb2 #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned STRB_W = DATA_W / 8,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic              req0_wen_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_wdata_i,
  input  logic [STRB_W-1:0] req0_wstrb_i,

  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic              req1_wen_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_wdata_i,
  input  logic [STRB_W-1:0] req1_wstrb_i,

  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic [DATA_W-1:0] rsp0_rdata_o,

  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [DATA_W-1:0] rsp1_rdata_o,

  output logic              sram_cen_o,
  output logic              sram_wen_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  output logic [STRB_W-1:0] sram_wstrb_o,
  input  logic [DATA_W-1:0] sram_rdata_i
);

  logic [1:0]        req_valid, req_wen, rsp_ready, elig, grant;
  logic [1:0]        inflight_q, inflight_d, rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q [2];
  logic [DATA_W-1:0] rsp_rdata_d [2];
  logic              prio_q, prio_d;

  assign req_valid = {req1_valid_i, req0_valid_i};
  assign req_wen   = {req1_wen_i, req0_wen_i};
  assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};

  // A read is only issued when its response register is guaranteed free at capture time.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid[i] &
                (req_wen[i] | (~inflight_q[i] & (~rsp_valid_q[i] | rsp_ready[i])));
    end
    grant[0] = ~rst_i & elig[0] & (~elig[1] | ~(RR_EN & prio_q));
    grant[1] = ~rst_i & elig[1] & (~elig[0] | (RR_EN & prio_q));
  end

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];

  always_comb begin
    sram_cen_o   = grant[0] | grant[1];
    sram_wen_o   = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_wstrb_o = '0;
    if (grant[0]) begin
      sram_wen_o   = req0_wen_i;
      sram_addr_o  = req0_addr_i;
      sram_wdata_o = req0_wdata_i;
      sram_wstrb_o = req0_wstrb_i;
    end else if (grant[1]) begin
      sram_wen_o   = req1_wen_i;
      sram_addr_o  = req1_addr_i;
      sram_wdata_o = req1_wdata_i;
      sram_wstrb_o = req1_wstrb_i;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (grant[0]) begin
      prio_d = 1'b1;
    end else if (grant[1]) begin
      prio_d = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      inflight_d[i]  = grant[i] & ~req_wen[i];
      rsp_valid_d[i] = rsp_valid_q[i];
      rsp_rdata_d[i] = rsp_rdata_q[i];
      if (rsp_valid_q[i] & rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
      // Capture overrides a same-cycle consume.
      if (inflight_q[i]) begin
        rsp_valid_d[i] = 1'b1;
        rsp_rdata_d[i] = sram_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q      <= 1'b0;
      inflight_q  <= '0;
      rsp_valid_q <= '0;
      for (int i = 0; i < 2; i++) begin
        rsp_rdata_q[i] <= '0;
      end
    end else begin
      prio_q      <= prio_d;
      inflight_q  <= inflight_d;
      rsp_valid_q <= rsp_valid_d;
      for (int i = 0; i < 2; i++) begin
        rsp_rdata_q[i] <= rsp_rdata_d[i];
      end
    end
  end

  assign rsp0_valid_o = rsp_valid_q[0];
  assign rsp1_valid_o = rsp_valid_q[1];
  assign rsp0_rdata_o = rsp_rdata_q[0];
  assign rsp1_rdata_o = rsp_rdata_q[1];

endmodule

// File: tb/tb_std_spram_arb2.sv
// Directed bench for std_spram_arb2: a round-robin and a fixed-priority instance share
// the same stimulus, each backed by its own behavioural 1-cycle-latency SRAM.
module tb_std_spram_arb2;

  localparam logic [127:0] PatA5 = {16{8'hA5}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = '0, req_wen = '0, rsp_ready = 2'b11;
  logic [9:0]   req_addr  [2];
  logic [127:0] req_wdata [2];
  logic [15:0]  req_wstrb [2];

  logic [1:0]   req_ready, rsp_valid, f_req_ready, f_rsp_valid;
  logic [127:0] rsp_rdata [2];
  logic [127:0] f_rsp_rdata [2];

  logic         s_cen, s_wen, f_cen, f_wen;
  logic [9:0]   s_addr, f_addr;
  logic [127:0] s_wdata, s_rdata, f_wdata, f_rdata;
  logic [15:0]  s_wstrb, f_wstrb;
  logic [127:0] mem_rr [1024];
  logic [127:0] mem_fp [1024];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  std_spram_arb2 #(.RR_EN(1'b1)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(req_valid[0]), .req0_ready_o(req_ready[0]), .req0_wen_i(req_wen[0]),
    .req0_addr_i(req_addr[0]), .req0_wdata_i(req_wdata[0]), .req0_wstrb_i(req_wstrb[0]),
    .req1_valid_i(req_valid[1]), .req1_ready_o(req_ready[1]), .req1_wen_i(req_wen[1]),
    .req1_addr_i(req_addr[1]), .req1_wdata_i(req_wdata[1]), .req1_wstrb_i(req_wstrb[1]),
    .rsp0_valid_o(rsp_valid[0]), .rsp0_ready_i(rsp_ready[0]), .rsp0_rdata_o(rsp_rdata[0]),
    .rsp1_valid_o(rsp_valid[1]), .rsp1_ready_i(rsp_ready[1]), .rsp1_rdata_o(rsp_rdata[1]),
    .sram_cen_o(s_cen), .sram_wen_o(s_wen), .sram_addr_o(s_addr),
    .sram_wdata_o(s_wdata), .sram_wstrb_o(s_wstrb), .sram_rdata_i(s_rdata)
  );

  std_spram_arb2 #(.RR_EN(1'b0)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(req_valid[0]), .req0_ready_o(f_req_ready[0]), .req0_wen_i(req_wen[0]),
    .req0_addr_i(req_addr[0]), .req0_wdata_i(req_wdata[0]), .req0_wstrb_i(req_wstrb[0]),
    .req1_valid_i(req_valid[1]), .req1_ready_o(f_req_ready[1]), .req1_wen_i(req_wen[1]),
    .req1_addr_i(req_addr[1]), .req1_wdata_i(req_wdata[1]), .req1_wstrb_i(req_wstrb[1]),
    .rsp0_valid_o(f_rsp_valid[0]), .rsp0_ready_i(rsp_ready[0]), .rsp0_rdata_o(f_rsp_rdata[0]),
    .rsp1_valid_o(f_rsp_valid[1]), .rsp1_ready_i(rsp_ready[1]), .rsp1_rdata_o(f_rsp_rdata[1]),
    .sram_cen_o(f_cen), .sram_wen_o(f_wen), .sram_addr_o(f_addr),
    .sram_wdata_o(f_wdata), .sram_wstrb_o(f_wstrb), .sram_rdata_i(f_rdata)
  );

  always @(posedge clk) begin
    if (s_cen) begin
      if (s_wen) begin
        for (int b = 0; b < 16; b++) begin
          if (s_wstrb[b]) mem_rr[s_addr][b*8 +: 8] <= s_wdata[b*8 +: 8];
        end
      end else begin
        s_rdata <= mem_rr[s_addr];
      end
    end
  end

  always @(posedge clk) begin
    if (f_cen) begin
      if (f_wen) begin
        for (int b = 0; b < 16; b++) begin
          if (f_wstrb[b]) mem_fp[f_addr][b*8 +: 8] <= f_wdata[b*8 +: 8];
        end
      end else begin
        f_rdata <= mem_fp[f_addr];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input int p, input logic w, input logic [9:0] a,
                       input logic [127:0] d, input logic [15:0] s);
    req_valid[p] = 1'b1;
    req_wen[p]   = w;
    req_addr[p]  = a;
    req_wdata[p] = d;
    req_wstrb[p] = s;
  endtask

  task automatic test_reset();
    tick();
    drive(0, 1'b1, 10'h001, 128'h1, 16'hFFFF);
    #1;
    checks++; if (req_ready !== 2'b00) begin errs++; $display("FAIL rst_ready: got %b exp 00", req_ready); end
    checks++; if (s_cen !== 1'b0) begin errs++; $display("FAIL rst_cen: got %b exp 0", s_cen); end
    checks++; if (f_cen !== 1'b0) begin errs++; $display("FAIL rst_cen_fp: got %b exp 0", f_cen); end
    tick();
    tick();
    rst = 1'b0;
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL rst_rsp_valid: got %b exp 00", rsp_valid); end
    checks++; if (rsp_rdata[0] !== '0) begin errs++; $display("FAIL rst_rdata0: got %h exp 0", rsp_rdata[0]); end
    checks++; if (rsp_rdata[1] !== '0) begin errs++; $display("FAIL rst_rdata1: got %h exp 0", rsp_rdata[1]); end
    checks++; if (s_cen !== 1'b0 || s_addr !== '0) begin errs++; $display("FAIL idle_sram: got cen=%b addr=%h exp 0/0", s_cen, s_addr); end
  endtask

  task automatic test_write_read();
    tick();
    drive(0, 1'b1, 10'h3FF, PatA5, 16'hFFFF);
    #1;
    checks++; if (req_ready !== 2'b01) begin errs++; $display("FAIL wr_grant: got %b exp 01", req_ready); end
    checks++; if ({s_cen, s_wen, s_addr} !== {2'b11, 10'h3FF}) begin errs++; $display("FAIL wr_sram: got cen=%b wen=%b addr=%h exp 1/1/3ff", s_cen, s_wen, s_addr); end
    tick();
    drive(0, 1'b0, 10'h3FF, '0, '0);
    #1;
    checks++; if ({req_ready, s_wen} !== 3'b010) begin errs++; $display("FAIL rd_grant: got ready=%b wen=%b exp 01/0", req_ready, s_wen); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid[0] !== 1'b0) begin errs++; $display("FAIL rd_lat1: got %b exp 0", rsp_valid[0]); end
    tick();
    #1;
    checks++; if (rsp_valid[0] !== 1'b1) begin errs++; $display("FAIL rd_lat2: got %b exp 1", rsp_valid[0]); end
    checks++; if (rsp_rdata[0] !== PatA5) begin errs++; $display("FAIL rd_data: got %h exp %h", rsp_rdata[0], PatA5); end
    tick();
    #1;
    checks++; if (rsp_valid[0] !== 1'b0) begin errs++; $display("FAIL rd_consume: got %b exp 0", rsp_valid[0]); end
  endtask

  task automatic test_byte_strobe();
    tick();
    drive(0, 1'b1, 10'h200, '0, 16'hFFFF);
    tick();
    drive(0, 1'b1, 10'h200, {128{1'b1}}, 16'h0001);
    #1;
    checks++; if (s_wstrb !== 16'h0001) begin errs++; $display("FAIL bs_wstrb: got %h exp 0001", s_wstrb); end
    tick();
    drive(0, 1'b0, 10'h200, '0, '0);
    tick();
    req_valid = '0;
    tick();
    #1;
    checks++; if (rsp_valid[0] !== 1'b1) begin errs++; $display("FAIL bs_valid: got %b exp 1", rsp_valid[0]); end
    checks++; if (rsp_rdata[0] !== 128'hFF) begin errs++; $display("FAIL bs_data: got %h exp ff", rsp_rdata[0]); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    tick();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    drive(0, 1'b0, 10'h3FF, '0, '0);
    drive(1, 1'b0, 10'h200, '0, '0);
    for (int k = 0; k < 8; k++) begin
      if (k != 0) tick();
      #1;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (req_ready !== exp_g) begin errs++; $display("FAIL rr_grant[%0d]: got %b exp %b", k, req_ready, exp_g); end
      checks++; if (s_cen !== 1'b1) begin errs++; $display("FAIL rr_cen[%0d]: got %b exp 1", k, s_cen); end
      if (k >= 2) begin
        checks++; if (rsp_valid !== exp_g) begin errs++; $display("FAIL rr_rsp[%0d]: got %b exp %b", k, rsp_valid, exp_g); end
        if (k % 2 == 0) begin
          checks++; if (rsp_rdata[0] !== PatA5) begin errs++; $display("FAIL rr_data0[%0d]: got %h exp %h", k, rsp_rdata[0], PatA5); end
        end else begin
          checks++; if (rsp_rdata[1] !== 128'hFF) begin errs++; $display("FAIL rr_data1[%0d]: got %h exp ff", k, rsp_rdata[1]); end
        end
      end
    end
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    tick();
    rsp_ready = 2'b01;
    drive(1, 1'b1, 10'h005, 128'h11, 16'hFFFF);
    #1;
    checks++; if (req_ready !== 2'b10) begin errs++; $display("FAIL bp_wr1: got %b exp 10", req_ready); end
    tick();
    drive(1, 1'b0, 10'h005, '0, '0);
    #1;
    checks++; if (req_ready !== 2'b10) begin errs++; $display("FAIL bp_rd1: got %b exp 10", req_ready); end
    tick();
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      drive(1, 1'b0, 10'h3FF, '0, '0);
      drive(0, 1'b1, 10'(6 + k), 128'(k), 16'hFFFF);
      #1;
      checks++; if (req_ready !== 2'b01) begin errs++; $display("FAIL bp_grant[%0d]: got %b exp 01", k, req_ready); end
      checks++; if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 128'h11) begin errs++; $display("FAIL bp_hold[%0d]: got v=%b d=%h exp 1/11", k, rsp_valid[1], rsp_rdata[1]); end
    end
    tick();
    rsp_ready = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b10) begin errs++; $display("FAIL bp_release: got %b exp 10", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid[1] !== 1'b0) begin errs++; $display("FAIL bp_drain: got %b exp 0", rsp_valid[1]); end
    tick();
    #1;
    checks++; if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== PatA5) begin errs++; $display("FAIL bp_rsp: got v=%b d=%h exp 1/%h", rsp_valid[1], rsp_rdata[1], PatA5); end
    tick();
  endtask

  task automatic test_fixed_priority();
    tick();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 10'h010, 128'h10, 16'hFFFF);
    drive(1, 1'b1, 10'h011, 128'h11, 16'hFFFF);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick();
      #1;
      checks++; if (f_req_ready !== 2'b01 || f_cen !== 1'b1) begin errs++; $display("FAIL fp_grant[%0d]: got %b cen=%b exp 01/1", k, f_req_ready, f_cen); end
    end
    tick();
    req_valid[0] = 1'b0;
    #1;
    checks++; if (f_req_ready !== 2'b10 || f_addr !== 10'h011) begin errs++; $display("FAIL fp_port1: got %b addr=%h exp 10/011", f_req_ready, f_addr); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_reset_mid_read();
    tick();
    drive(0, 1'b0, 10'h3FF, '0, '0);
    #1;
    checks++; if (req_ready !== 2'b01) begin errs++; $display("FAIL rmr_grant: got %b exp 01", req_ready); end
    tick();
    rst = 1'b1;
    drive(0, 1'b1, 10'h020, 128'h5, 16'hFFFF);
    #1;
    checks++; if (req_ready !== 2'b00 || s_cen !== 1'b0) begin errs++; $display("FAIL rmr_inrst: got ready=%b cen=%b exp 00/0", req_ready, s_cen); end
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 10'h020, 128'h5, 16'hFFFF);
    drive(1, 1'b1, 10'h021, 128'h6, 16'hFFFF);
    #1;
    checks++; if (req_ready !== 2'b01) begin errs++; $display("FAIL rmr_prio: got %b exp 01", req_ready); end
    checks++; if (rsp_valid[0] !== 1'b0) begin errs++; $display("FAIL rmr_valid: got %b exp 0", rsp_valid[0]); end
    checks++; if (rsp_rdata[0] !== '0) begin errs++; $display("FAIL rmr_rdata: got %h exp 0", rsp_rdata[0]); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL rmr_later: got %b exp 00", rsp_valid); end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      req_wstrb[i] = '0;
    end
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_round_robin();
    test_backpressure();
    test_fixed_priority();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/std_spram_arb2.md
# std_spram_arb2

Two-requester arbiter that shares one 1024x128b single-port SRAM wrapper instance between two masters, for example a DMA fill path and a compute read path. Each requester has a valid/ready request channel and a valid/ready read-response channel. The block issues at most one SRAM access per cycle, using round-robin (or fixed) priority. It captures the SRAM's 1-cycle read data into a per-requester response register, so backpressure on a response never blocks the other requester.

## Interface
- ADDR_W, 10, SRAM word-address width.
- DATA_W, 128, SRAM word width.
- STRB_W, DATA_W/8, byte-strobe width.
- RR_EN, 1, 1 = round-robin; 0 = fixed priority, port 0 wins.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- reqN_valid  in  1  request valid (N = 0, 1).
- reqN_ready  out  1  request accepted this cycle (granted).
- reqN_wen  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_W  word address.
- reqN_wdata  in  DATA_W  write data.
- reqN_wstrb  in  STRB_W  byte enables (writes only).
- rspN_valid  out  1  read data available.
- rspN_ready  in  1  consumer takes read data.
- rspN_rdata  out  DATA_W  read data; stable while rspN_valid && !rspN_ready.
- sram_cen  out  1  SRAM access enable (active-high).
- sram_wen  out  1  1 = write.
- sram_addr  out  ADDR_W  to SRAM addr.
- sram_wdata  out  DATA_W  to SRAM wdata.
- sram_wstrb  out  STRB_W  to SRAM wstrb.
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read access.

## Operation
- **Eligibility:**
  - A write on port N is eligible whenever reqN_valid is high.
  - A read on port N is eligible iff reqN_valid && !inflightN && (!rspN_valid || rspN_ready).
- **Grant:**
  - If exactly one port is eligible, it is granted.
  - If both are eligible and RR_EN=1, the port pointed to by prio is granted.
  - If both are eligible and RR_EN=0, port 0 is granted.
  - The grant is combinational in the same cycle: reqN_ready = grantN.
- **Round-robin pointer:** after a grant to port N, prio <= ~N. The pointer holds when nothing is granted.
- **SRAM drive:**
  - sram_cen = grant0 | grant1.
  - sram_wen, sram_addr, sram_wdata and sram_wstrb are muxed from the granted port.
  - When idle, the SRAM outputs drive 0.
- **Read tracking:** on a granted read from port N, set inflightN <= 1 (cleared the next cycle). inflight0 and inflight1 are never set together.
- **Response capture:**
  - When inflightN is high, rspN_rdata <= sram_rdata and rspN_valid <= 1.
  - rspN_valid clears on rspN_valid && rspN_ready unless a capture occurs in the same cycle; capture wins.
- **Writes:** no response is returned. Write ordering against later reads holds because there is a single SRAM port and accesses are issued in grant order.
- **Reset:**
  - prio=0, inflight0/1=0, rsp0_valid=rsp1_valid=0, rsp0_rdata=rsp1_rdata=0.
  - While rst is high: req0_ready=req1_ready=0 and sram_cen=0.
  - A read granted in the cycle before rst asserts is discarded; it never produces a response.
- **Requester contract:** a requester holds its request fields stable while reqN_valid && !reqN_ready. Dropping valid before ready is allowed; the block keeps no state for unaccepted requests.

## Timing
- Read latency is 2 cycles: a read granted in cycle t reaches the SRAM in t, sram_rdata is valid in t+1, and rspN_valid=1 from t+2.
- Per-port read throughput is 1 read every 2 cycles, because inflight blocks back-to-back grants.
- Alternating ports sustain 1 SRAM access per cycle.
- Write-to-read hazard: a write in cycle t followed by a read of the same address in t+1 returns the new data.
- Response backpressure: rspN_valid held with rspN_ready low blocks further reads on port N only. Port N writes and all port ~N traffic continue.
- A port stalled by rspN_valid && !rspN_ready becomes eligible in the same cycle rspN_ready rises.
- Starvation bound with RR_EN=1: a continuously eligible port is granted within 2 cycles.

## Test plan
- **Write then read:**
  - Stimulus: port0 writes addr 0x3FF, data 0xA5..A5, wstrb 0xFFFF; next cycle port0 reads 0x3FF.
  - Required response: rsp0_valid 2 cycles after the read grant, rsp0_rdata=0xA5..A5.
- **Byte strobe:**
  - Stimulus: write 0 to addr 0x200; write all-ones with wstrb 0x0001; read 0x200.
  - Required response: rdata = 0x00..00FF.
- **Round-robin:**
  - Stimulus: both ports hold reads continuously with rsp_ready=1.
  - Required response: grants alternate 0,1,0,1 starting with port 0 after reset; sram_cen=1 every cycle; each port receives 1 response every 2 cycles.
- **Backpressure isolation:**
  - Stimulus: rsp1_ready=0 with rsp1 holding data 0x11; port1 issues a read; port0 writes.
  - Required response: port1 is not granted and rsp1_rdata stays 0x11; port0 writes are granted every cycle. Raising rsp1_ready grants port1 in that cycle.
- **Fixed priority:**
  - Stimulus: RR_EN=0, both ports issue writes continuously.
  - Required response: only port 0 is granted; port 1 is granted in the first cycle port 0 drops valid.
- **Reset mid-read:**
  - Stimulus: grant a port0 read in cycle t, assert rst in t+1 for 1 cycle.
  - Required response: rsp0_valid stays 0; after rst deasserts, prio=0 and outputs are at their reset values.
